// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ producers share a
// single FIFO write port. One write is in flight at a time
// (IDLE -> WRITE -> ACK_WAIT). The FIFO's acknowledge decides whether the
// producer is granted or whether it retries in the next arbitration.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic [7:0]                    retry_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] ACK_WAIT = 2'd2;

    logic [1:0]            state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      winner;
    logic [PTR_W-1:0]      sel;
    logic                  sel_valid;
    logic [FIFO_WIDTH-1:0] sel_data;
    logic [PTR_W-1:0]      winner_next;

    // Overflow is informational only: a missing acknowledge already marks
    // the attempt as failed, whatever the reason.
    logic unused_overflow;
    assign unused_overflow = fifo_overflow;

    // Round-robin pick: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the loops can leave a value held (no latch).
        sel       = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!sel_valid && req[j] && (PTR_W'(j) >= ptr)) begin
                sel       = PTR_W'(j);
                sel_valid = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!sel_valid && req[j]) begin
                sel       = PTR_W'(j);
                sel_valid = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sel == PTR_W'(j)) begin
                sel_data = req_data[j*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Pointer value that follows a successful grant, wrapping at NUM_REQ.
    always_comb begin
        if (winner == PTR_W'(NUM_REQ - 1)) begin
            winner_next = '0;
        end else begin
            winner_next = winner + 1'b1;
        end
    end

    // Grant pulses only while an acknowledged write is being retired.
    always_comb begin
        gnt = '0;
        if (!rst && (state == ACK_WAIT) && fifo_wr_ack) begin
            gnt[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // Write-cycle sequencer: arbitrate, issue one write, retire on ack/no-ack.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here updates from
        // the values present before the edge, independent of statement order.
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            winner       <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            retry_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid && !fifo_full) begin
                        winner       <= sel;
                        fifo_data_in <= sel_data;
                        fifo_wr_en   <= 1'b1;
                        state        <= WRITE;
                    end else begin
                        fifo_wr_en <= 1'b0;
                    end
                end
                WRITE: begin
                    fifo_wr_en <= 1'b0;
                    state      <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (fifo_wr_ack) begin
                        ptr <= winner_next;
                    end else begin
                        // Failed attempt: the same producer wins next time.
                        ptr <= winner;
                        if (retry_cnt != 8'hFF) begin
                            retry_cnt <= retry_cnt + 8'd1;
                        end
                    end
                    state <= IDLE;
                end
                default: begin
                    fifo_wr_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Producers and a FIFO responder are
// modelled here; expected writes and grants are queued when stimulus is
// applied and compared by a monitor as the DUT produces them.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W       = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*W-1:0]   req_data;
    logic [NUM_REQ-1:0]     gnt;
    logic                   fifo_wr_en;
    logic [W-1:0]           fifo_data_in;
    logic                   fifo_full = 1'b0;
    logic                   fifo_wr_ack = 1'b0;
    logic                   fifo_overflow = 1'b0;
    logic                   busy;
    logic [7:0]             retry_cnt;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_wr_ack  (fifo_wr_ack),
        .fifo_overflow(fifo_overflow),
        .busy         (busy),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;

    // Producer model state: words still to send and the current word.
    int         cnt [NUM_REQ];
    logic [W-1:0] word [NUM_REQ];
    logic [NUM_REQ-1:0] gnt_seen = '0;

    // FIFO responder state.
    logic       prev_wr = 1'b0;
    logic [W-1:0] prev_data = '0;
    int         fail_cnt = 0;
    logic [W-1:0] fail_data = '0;

    // Scoreboard and bookkeeping.
    logic [W-1:0]       exp_wr_q [$];
    logic [NUM_REQ-1:0] exp_gnt_q [$];
    int                 gnt_cyc_q [$];
    int cyc = 0;
    int last_wr_cyc = 0;
    int last_gnt_cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]              = (cnt[i] != 0);
            req_data[i*W +: W]  = word[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += cnt[i];
        return s;
    endfunction

    // FIFO responder and producer bookkeeping, just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            fifo_wr_ack   = 1'b0;
            fifo_overflow = 1'b0;
            if (prev_wr) begin
                if (fail_cnt > 0 && prev_data == fail_data) begin
                    fifo_overflow = 1'b1;
                    fail_cnt--;
                end else begin
                    fifo_wr_ack = 1'b1;
                end
            end
            prev_wr   = (fifo_wr_en === 1'b1);
            prev_data = fifo_data_in;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_seen[i]) begin
                    if (cnt[i] > 0) cnt[i]--;
                    word[i] = word[i] + 1'b1;
                end
            end
            gnt_seen = '0;
        end
    end

    // Monitor: compare writes and grants against the scoreboard mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) check("gnt_in_rst", 32'(gnt), 32'd0);
            if (fifo_wr_en === 1'b1) begin
                last_wr_cyc = cyc;
                if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(fifo_wr_en), 32'd0);
                else check("wr_data", 32'(fifo_data_in), 32'(exp_wr_q.pop_front()));
            end
            if (gnt !== '0) begin
                gnt_seen     = gnt;
                last_gnt_cyc = cyc;
                gnt_cyc_q.push_back(cyc);
                if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
                else check("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        fail_cnt  = 0;
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(fifo_data_in), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        exp_wr_q.delete();
        exp_gnt_q.delete();
        gnt_cyc_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (exp_wr_q.size() == 0 && exp_gnt_q.size() == 0 && !busy && pending() == 0) break;
        end
        check(tag, 32'(exp_wr_q.size() + exp_gnt_q.size() + pending()), 32'd0);
    endtask

    task automatic wait_write(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (fifo_wr_en === 1'b1) break;
        end
        check(tag, 32'(fifo_wr_en), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i]  = 0;
            word[i] = '0;
        end

        do_reset();

        // Single producer with known latency, then data hold.
        word[0] = 16'h0F0F; word[1] = 16'hA5A5; word[2] = 16'h3C3C; word[3] = 16'hC3C3;
        exp_wr_q.push_back(16'hA5A5);
        exp_gnt_q.push_back(4'b0010);
        t0 = cyc;
        cnt[1] = 1;
        drain("single_drain", 20);
        check("single_wr_lat", 32'(last_wr_cyc - t0), 32'd1);
        check("single_gnt_lat", 32'(last_gnt_cyc - t0), 32'd2);
        check("single_hold", 32'(fifo_data_in), 32'h0000A5A5);

        // ptr is now 2: requesters 0,1,3 must be served as 3,0,1.
        exp_wr_q.push_back(word[3]);
        exp_wr_q.push_back(word[0]);
        exp_wr_q.push_back(word[1]);
        exp_gnt_q.push_back(4'b1000);
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0010);
        cnt[0] = 1; cnt[1] = 1; cnt[3] = 1;
        drain("ptr_drain", 40);

        // Fairness from ptr=0, all requesting: 0,1,2,3,0 three cycles apart.
        do_reset();
        word[0] = 16'h1001; word[1] = 16'h2002; word[2] = 16'h3003; word[3] = 16'h4004;
        exp_wr_q.push_back(16'h1001); exp_wr_q.push_back(16'h2002);
        exp_wr_q.push_back(16'h3003); exp_wr_q.push_back(16'h4004);
        exp_wr_q.push_back(16'h1002);
        exp_gnt_q.push_back(4'b0001); exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0100); exp_gnt_q.push_back(4'b1000);
        exp_gnt_q.push_back(4'b0001);
        cnt[0] = 2; cnt[1] = 1; cnt[2] = 1; cnt[3] = 1;
        drain("fair_drain", 60);
        check("fair_gnt_count", 32'(gnt_cyc_q.size()), 32'd5);
        for (int i = 1; i < gnt_cyc_q.size(); i++) begin
            check("fair_spacing", 32'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 32'd3);
        end

        // FIFO full blocks arbitration; full rising mid-write does not abort.
        do_reset();
        fifo_full = 1'b1;
        word[0] = 16'h1234;
        exp_wr_q.push_back(16'h1234);
        exp_gnt_q.push_back(4'b0001);
        cnt[0] = 1;
        repeat (5) begin
            @(posedge clk);
            #2;
            check("full_wr_en", 32'(fifo_wr_en), 32'd0);
            check("full_busy", 32'(busy), 32'd0);
        end
        fifo_full = 1'b0;
        wait_write("full_release_wr", 10);
        fifo_full = 1'b1;
        drain("full_inflight_drain", 20);
        fifo_full = 1'b0;

        // Overflow on producer 2: no grant, retry_cnt=1, producer 2 rewrites.
        do_reset();
        word[0] = 16'h0A0A; word[1] = 16'h0B0B; word[2] = 16'h0C0C; word[3] = 16'h0D0D;
        fail_data = 16'h0C0C;
        fail_cnt  = 1;
        exp_wr_q.push_back(16'h0A0A); exp_wr_q.push_back(16'h0B0B);
        exp_wr_q.push_back(16'h0C0C); exp_wr_q.push_back(16'h0C0C);
        exp_wr_q.push_back(16'h0D0D);
        exp_gnt_q.push_back(4'b0001); exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0100); exp_gnt_q.push_back(4'b1000);
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 1;
        drain("ovf_drain", 80);
        check("ovf_retry_cnt", 32'(retry_cnt), 32'd1);
        check("ovf_fail_used", 32'(fail_cnt), 32'd0);

        // 300 failed attempts saturate retry_cnt at 255.
        do_reset();
        word[1]   = 16'h5A5A;
        fail_data = 16'h5A5A;
        fail_cnt  = 300;
        for (int i = 0; i < 301; i++) exp_wr_q.push_back(16'h5A5A);
        exp_gnt_q.push_back(4'b0010);
        cnt[1] = 1;
        drain("sat_drain", 1200);
        check("sat_retry_cnt", 32'(retry_cnt), 32'd255);

        // Reset during ACK_WAIT: attempt abandoned, no grant, outputs cleared.
        word[3] = 16'h7E7E;
        exp_wr_q.push_back(16'h7E7E);
        cnt[3] = 1;
        wait_write("rst_aw_write", 10);
        @(posedge clk);
        #2;
        check("rst_aw_busy", 32'(busy), 32'd1);
        rst    = 1'b1;
        cnt[3] = 0;
        @(posedge clk);
        #2;
        check("rst_aw_gnt", 32'(gnt), 32'd0);
        check("rst_aw_busy_clr", 32'(busy), 32'd0);
        check("rst_aw_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_aw_data", 32'(fifo_data_in), 32'd0);
        check("rst_aw_retry", 32'(retry_cnt), 32'd0);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #2;
            check("rst_aw_idle_wr", 32'(fifo_wr_en), 32'd0);
        end
        check("rst_aw_queue", 32'(exp_wr_q.size() + exp_gnt_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
